// File: rtl/seg_scan_ctrl.sv
// Scan controller for a 4-digit common-anode 7-segment display.
// Values enter a pending register by handshake and reach the display only at frame boundaries.
module seg_scan_ctrl #(
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] load_value,
  input  logic [3:0]  load_dp,
  input  logic [3:0]  blank_mask,
  input  logic        lz_blank,
  output logic [3:0]  an,
  output logic [7:0]  seg,
  output logic        frame_tick
);
  localparam int MAXC = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;

  typedef enum logic {BLANK, SHOW} st_t;

  st_t         st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]  dig, dig_n;
  logic [15:0] shadow, shadow_n, pend;
  logic [3:0]  sdp, sdp_n, pdp;
  logic        pend_vld, pend_vld_n;
  logic        xfer, boundary;
  logic [3:0]  nib, lzb, an_n;
  logic [7:0]  seg_n;

  function automatic logic [6:0] enc(input logic [3:0] n);
    case (n)
      4'h0: enc = 7'h40; 4'h1: enc = 7'h79; 4'h2: enc = 7'h24; 4'h3: enc = 7'h30;
      4'h4: enc = 7'h19; 4'h5: enc = 7'h12; 4'h6: enc = 7'h02; 4'h7: enc = 7'h78;
      4'h8: enc = 7'h00; 4'h9: enc = 7'h10; 4'hA: enc = 7'h08; 4'hB: enc = 7'h03;
      4'hC: enc = 7'h46; 4'hD: enc = 7'h21; 4'hE: enc = 7'h06; default: enc = 7'h0E;
    endcase
  endfunction

  always_comb begin
    st_n     = st;
    cnt_n    = cnt + CW'(1);
    dig_n    = dig;
    boundary = 1'b0;
    case (st)
      BLANK: if (cnt == CW'(BLANK_CYCLES - 1)) begin
        st_n  = SHOW;
        cnt_n = '0;
      end
      default: if (cnt == CW'(DIGIT_CYCLES - 1)) begin
        st_n     = BLANK;
        cnt_n    = '0;
        dig_n    = dig + 2'd1;
        boundary = (dig == 2'd3);
      end
    endcase
  end

  // load_ready mirrors "nothing pending", so a transfer never coincides with a shadow update
  always_comb begin
    xfer       = load_valid & load_ready;
    shadow_n   = shadow;
    sdp_n      = sdp;
    if (boundary && pend_vld) begin
      shadow_n = pend;
      sdp_n    = pdp;
    end
    pend_vld_n = xfer | (pend_vld & ~boundary);
  end

  // Outputs are registered from next-cycle state so they line up with the FSM phase
  always_comb begin
    nib    = shadow_n[{dig_n, 2'b00} +: 4];
    lzb[3] = lz_blank & (shadow_n[15:12] == 4'h0);
    lzb[2] = lzb[3] & (shadow_n[11:8] == 4'h0);
    lzb[1] = lzb[2] & (shadow_n[7:4] == 4'h0);
    lzb[0] = 1'b0;
    an_n   = 4'hF;
    seg_n  = 8'hFF;
    if (st_n == SHOW && !blank_mask[dig_n] && !lzb[dig_n]) begin
      an_n  = ~(4'b0001 << dig_n);
      seg_n = {~sdp_n[dig_n], enc(nib)};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st         <= BLANK;
      cnt        <= '0;
      dig        <= 2'd0;
      shadow     <= 16'h0;
      sdp        <= 4'h0;
      pend       <= 16'h0;
      pdp        <= 4'h0;
      pend_vld   <= 1'b0;
      an         <= 4'hF;
      seg        <= 8'hFF;
      frame_tick <= 1'b0;
      load_ready <= 1'b1;
    end else begin
      st         <= st_n;
      cnt        <= cnt_n;
      dig        <= dig_n;
      shadow     <= shadow_n;
      sdp        <= sdp_n;
      pend_vld   <= pend_vld_n;
      if (xfer) begin
        pend <= load_value;
        pdp  <= load_dp;
      end
      an         <= an_n;
      seg        <= seg_n;
      frame_tick <= boundary & pend_vld;
      load_ready <= ~pend_vld_n;
    end
  end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed scenarios then random traffic, each cycle checked
// against a frame-position model derived from the display rules.
module tb_seg_scan_ctrl;
  localparam int D  = 4;
  localparam int B  = 2;
  localparam int FL = 4 * (B + D);

  logic        clk = 1'b0;
  logic        reset, load_valid, load_ready, lz_blank, frame_tick;
  logic [15:0] load_value;
  logic [3:0]  load_dp, blank_mask, an;
  logic [7:0]  seg;

  seg_scan_ctrl #(.DIGIT_CYCLES(D), .BLANK_CYCLES(B)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
    .load_value(load_value), .load_dp(load_dp), .blank_mask(blank_mask),
    .lz_blank(lz_blank), .an(an), .seg(seg), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int ncmp = 0, nfail = 0;

  // model: t counts cycles since reset release; display follows from t mod FL
  int          t;
  logic [15:0] m_sh, m_pv;
  logic [3:0]  m_sdp, m_pdp, m_bm;
  bit          m_lz, m_pend, m_rdy, m_ft, m_live = 0, m_xfer;

  function automatic logic [6:0] enc(input logic [3:0] n);
    logic [7:0] tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    enc = tbl[n][6:0];
  endfunction

  task automatic check();
    int p, d, w;
    bit lzs;
    logic [3:0] e_an;
    logic [7:0] e_seg;
    if (!m_live) return;
    p = t % FL; d = p / (B + D); w = p % (B + D);
    e_an = 4'hF; e_seg = 8'hFF;
    if (w >= B) begin
      lzs = m_lz && d > 0 && ((m_sh >> (4 * d)) == 16'h0);
      if (!m_bm[d] && !lzs) begin
        e_an  = ~(4'b0001 << d);
        e_seg = {~m_sdp[d], enc(m_sh[4*d +: 4])};
      end
    end
    ncmp++;
    assert (an === e_an) else begin nfail++; $error("FAIL an t=%0d obs=%h exp=%h", t, an, e_an); end
    ncmp++;
    assert (seg === e_seg) else begin nfail++; $error("FAIL seg t=%0d obs=%h exp=%h", t, seg, e_seg); end
    ncmp++;
    assert (frame_tick === m_ft) else begin nfail++; $error("FAIL frame_tick t=%0d obs=%b exp=%b", t, frame_tick, m_ft); end
    ncmp++;
    assert (load_ready === m_rdy) else begin nfail++; $error("FAIL load_ready t=%0d obs=%b exp=%b", t, load_ready, m_rdy); end
  endtask

  task automatic model_edge();
    bit xf;
    m_xfer = 0;
    if (reset) begin
      t = 0; m_sh = 0; m_sdp = 0; m_pend = 0; m_rdy = 1; m_ft = 0; m_live = 1;
      m_bm = blank_mask; m_lz = lz_blank;
      return;
    end
    if (!m_live) return;
    xf   = load_valid && m_rdy;
    m_ft = 0;
    if ((t % FL) == FL - 1 && m_pend) begin
      m_sh = m_pv; m_sdp = m_pdp; m_pend = 0; m_rdy = 1; m_ft = 1;
    end
    if (xf) begin
      m_pv = load_value; m_pdp = load_dp; m_pend = 1; m_rdy = 0; m_xfer = 1;
    end
    m_bm = blank_mask; m_lz = lz_blank;
    t++;
  endtask

  task automatic tick();
    check();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    if (m_xfer) load_valid = 1'b0;
  endtask

  task automatic offer(input logic [15:0] v, input logic [3:0] dp);
    bit done = 0;
    load_value = v; load_dp = dp; load_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      tick();
      if (m_xfer) done = 1;
    end
    ncmp++;
    assert (done) else begin nfail++; $error("FAIL handshake value=%h obs=%b exp=1", v, done); end
    load_valid = 1'b0;
  endtask

  task automatic wait_phase(input int ph);
    for (int i = 0; i < FL && (t % FL) != ph; i++) tick();
  endtask

  initial begin
    reset = 1'b1; load_valid = 1'b0; load_value = 16'h0; load_dp = 4'h0;
    blank_mask = 4'h0; lz_blank = 1'b0;
    @(negedge clk);
    tick(); tick();
    reset = 1'b0;
    repeat (48) tick();

    offer(16'h1234, 4'b0001);
    repeat (60) tick();

    // second offer stalls behind the pending AAAA until the boundary
    offer(16'hAAAA, 4'h0);
    offer(16'hFFFF, 4'h0);
    repeat (60) tick();

    lz_blank = 1'b1;
    offer(16'h00A0, 4'h0);
    repeat (50) tick();
    offer(16'h0000, 4'h0);
    repeat (50) tick();
    lz_blank = 1'b0;
    offer(16'h5678, 4'b1010);
    repeat (30) tick();

    wait_phase(15);
    blank_mask = 4'b0100;
    repeat (30) tick();
    blank_mask = 4'h0;

    wait_phase(0);
    offer(16'h9ABC, 4'hF);
    wait_phase(14);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (60) tick();

    repeat (3000) begin
      if (!load_valid && $urandom_range(0, 9) == 0) begin
        load_valid = 1'b1;
        load_value = 16'($urandom) & (($urandom_range(0, 1) == 0) ? 16'h00FF : 16'hFFFF);
        load_dp    = 4'($urandom);
      end
      if ($urandom_range(0, 49) == 0)
        blank_mask = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      if ($urandom_range(0, 39) == 0) lz_blank = ~lz_blank;
      reset = ($urandom_range(0, 499) == 0);
      tick();
    end
    reset = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
